// File: rtl/system_timer_multi.sv
// Multi-channel system timer: divided free-running counter, compare channels, sticky status, level irq.
// Optional periodic auto-reload of compare registers is enabled with SYSTEM_TIMER_AUTORELOAD_EN.
module system_timer_multi #(
  parameter int CHANNELS    = 4,
  parameter int COUNT_WIDTH = 32,
  parameter int DIV_WIDTH   = 21,
  parameter int ADDR_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic                  read,
  input  logic [31:0]           writeData,
  output logic [31:0]           readData,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic                  irq
);

  localparam logic [ADDR_WIDTH-1:0] A_COUNT  = ADDR_WIDTH'(32'h00);
  localparam logic [ADDR_WIDTH-1:0] A_DIV    = ADDR_WIDTH'(32'h04);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(32'h08);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(32'h0C);

  function automatic logic [ADDR_WIDTH-1:0] cmp_addr(input int n);
    return ADDR_WIDTH'(32'h20 + 32'(8 * n));
  endfunction

  logic [COUNT_WIDTH-1:0] count_q, count_d, count_inc;
  logic [DIV_WIDTH-1:0]   divider_q, divider_d, divcnt_q, divcnt_d;
  logic                   enable_q, enable_d, oie_q, oie_d, ovf_q, ovf_d, ovf_set;
  logic [CHANNELS-1:0]    mie_q, mie_d, match_q, match_d, match_set;
  logic [COUNT_WIDTH-1:0] cmp_q [CHANNELS];
  logic [COUNT_WIDTH-1:0] cmp_d [CHANNELS];
`ifdef SYSTEM_TIMER_AUTORELOAD_EN
  logic [COUNT_WIDTH-1:0] reload_q [CHANNELS];
  logic [COUNT_WIDTH-1:0] reload_d [CHANNELS];
  logic [CHANNELS-1:0]    wr_rld;
`endif
  logic                   irq_q, irq_d;
  logic                   tick, eval, wr_count, wr_div, wr_ctrl, wr_status;
  logic [CHANNELS-1:0]    wr_cmp;
  logic                   unused_wdata;

  assign unused_wdata = ^writeData;
  assign irq          = irq_q;

  always_comb begin
    wr_count  = write && (address == A_COUNT);
    wr_div    = write && (address == A_DIV);
    wr_ctrl   = write && (address == A_CTRL);
    wr_status = write && (address == A_STATUS);
    for (int n = 0; n < CHANNELS; n++) begin
      wr_cmp[n] = write && (address == cmp_addr(n));
`ifdef SYSTEM_TIMER_AUTORELOAD_EN
      wr_rld[n] = write && (address == cmp_addr(n) + ADDR_WIDTH'(4));
`endif
    end
  end

  // A software COUNT write suppresses match/overflow evaluation for that tick.
  assign tick      = enable_q && (divcnt_q == divider_q);
  assign eval      = tick && !wr_count;
  assign count_inc = count_q + COUNT_WIDTH'(1);
  assign ovf_set   = eval && (&count_q);

  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      match_set[n] = eval && (count_inc == cmp_q[n]);
    end
  end

  always_comb begin
    divcnt_d  = divcnt_q;
    count_d   = count_q;
    divider_d = divider_q;
    enable_d  = enable_q;
    mie_d     = mie_q;
    oie_d     = oie_q;
    if (wr_div || tick)  divcnt_d = '0;
    else if (enable_q)   divcnt_d = divcnt_q + DIV_WIDTH'(1);
    if (wr_count)        count_d = writeData[COUNT_WIDTH-1:0];
    else if (tick)       count_d = count_inc;
    if (wr_div)          divider_d = writeData[DIV_WIDTH-1:0];
    if (wr_ctrl) begin
      enable_d = writeData[0];
      mie_d    = writeData[8 +: CHANNELS];
      oie_d    = writeData[31];
    end
    // Hardware set takes priority over a same-cycle write-1-to-clear.
    match_d = (match_q & ~(wr_status ? writeData[CHANNELS-1:0] : {CHANNELS{1'b0}})) | match_set;
    ovf_d   = (ovf_q & ~(wr_status & writeData[31])) | ovf_set;
    for (int n = 0; n < CHANNELS; n++) begin
      cmp_d[n] = cmp_q[n];
`ifdef SYSTEM_TIMER_AUTORELOAD_EN
      reload_d[n] = wr_rld[n] ? writeData[COUNT_WIDTH-1:0] : reload_q[n];
      if (wr_cmp[n])                                    cmp_d[n] = writeData[COUNT_WIDTH-1:0];
      else if (match_set[n] && (reload_q[n] != '0))     cmp_d[n] = cmp_q[n] + reload_q[n];
`else
      if (wr_cmp[n])                                    cmp_d[n] = writeData[COUNT_WIDTH-1:0];
`endif
    end
    irq_d = (|(match_q & mie_q)) | (ovf_q & oie_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      divider_q <= '0;
      divcnt_q  <= '0;
      enable_q  <= 1'b0;
      mie_q     <= '0;
      oie_q     <= 1'b0;
      match_q   <= '0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
      for (int n = 0; n < CHANNELS; n++) begin
        cmp_q[n] <= '1;
`ifdef SYSTEM_TIMER_AUTORELOAD_EN
        reload_q[n] <= '0;
`endif
      end
    end else begin
      count_q   <= count_d;
      divider_q <= divider_d;
      divcnt_q  <= divcnt_d;
      enable_q  <= enable_d;
      mie_q     <= mie_d;
      oie_q     <= oie_d;
      match_q   <= match_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
      for (int n = 0; n < CHANNELS; n++) begin
        cmp_q[n] <= cmp_d[n];
`ifdef SYSTEM_TIMER_AUTORELOAD_EN
        reload_q[n] <= reload_d[n];
`endif
      end
    end
  end

  always_comb begin
    readData = '0;
    if (read) begin
      if (address == A_COUNT)  readData = 32'(count_q);
      if (address == A_DIV)    readData = 32'(divider_q);
      if (address == A_CTRL) begin
        readData[0]             = enable_q;
        readData[8 +: CHANNELS] = mie_q;
        readData[31]            = oie_q;
      end
      if (address == A_STATUS) begin
        readData[CHANNELS-1:0] = match_q;
        readData[31]           = ovf_q;
      end
      for (int n = 0; n < CHANNELS; n++) begin
        if (address == cmp_addr(n)) readData = 32'(cmp_q[n]);
`ifdef SYSTEM_TIMER_AUTORELOAD_EN
        if (address == cmp_addr(n) + ADDR_WIDTH'(4)) readData = 32'(reload_q[n]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_system_timer_multi.sv
// Directed and randomized bench for system_timer_multi with an arithmetic timing model.
`timescale 1ns/1ps
module tb_system_timer_multi;
  localparam int CH = 4;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [31:0]   writeData = '0;
  logic [AW-1:0] address = '0;
  logic [31:0]   readData;
  logic          irq;

  int checks = 0;
  int passed = 0;

  system_timer_multi #(.CHANNELS(CH), .COUNT_WIDTH(32), .DIV_WIDTH(21), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .write(write), .read(read), .writeData(writeData),
    .readData(readData), .address(address), .irq(irq)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called in the low clock phase; the write is sampled by the next rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address   = a[AW-1:0];
    writeData = d;
    write     = 1'b1;
    @(negedge clk);
    write     = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    address = a[AW-1:0];
    read    = 1'b1;
    #1;
    d       = readData;
    read    = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check(tag, v, exp);
  endtask

  task automatic chk_masked(input string tag, input logic [31:0] a, input logic [31:0] m,
                            input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check(tag, v & m, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] start, ctrl, st_exp;
    logic [CH-1:0] m;
    logic oe, irq_exp;
    int d, k;
    int off [CH];
    longint ticks, tt, need;

    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk_reg("rst_count", 32'h00, 32'h0);
    chk_reg("rst_div", 32'h04, 32'h0);
    chk_reg("rst_ctrl", 32'h08, 32'h0);
    chk_reg("rst_status", 32'h0C, 32'h0);
    for (int n = 0; n < CH; n++) chk_reg($sformatf("rst_cmp%0d", n), 32'h20 + 32'(8 * n), 32'hFFFF_FFFF);
    chk_reg("rst_reload0", 32'h24, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    address = AW'(32'h20);
    read = 1'b0;
    #1;
    check("rdata_idle", readData, 32'h0);

    // Field widths and unmapped addresses
    wr(32'h08, 32'hFFFF_FFFF);
    chk_reg("ctrl_bits", 32'h08, 32'h8000_0F01);
    wr(32'h08, 32'h0);
    wr(32'h04, 32'hFFFF_FFFF);
    chk_reg("div_width", 32'h04, 32'h001F_FFFF);
    wr(32'h10, 32'h1234_5678);
    chk_reg("unmapped", 32'h10, 32'h0);
    wr(32'h00, 32'h0);
    wr(32'h0C, 32'hFFFF_FFFF);
    chk_reg("status_clr", 32'h0C, 32'h0);

    // Divider period 5
    wr(32'h04, 32'd4);
    wr(32'h08, 32'h1);
    cyc(4);
    chk_reg("div_t4", 32'h00, 32'd0);
    cyc(1);
    chk_reg("div_t5", 32'h00, 32'd1);
    cyc(45);
    chk_reg("div_t50", 32'h00, 32'd10);

    // Match on channel 0, irq latency, W1C
    wr(32'h08, 32'h0);
    wr(32'h04, 32'h0);
    wr(32'h00, 32'h0);
    wr(32'h20, 32'd3);
    wr(32'h0C, 32'h8000_00FF);
    wr(32'h08, 32'h101);
    cyc(3);
    chk_reg("m0_count", 32'h00, 32'd3);
    chk_reg("m0_status", 32'h0C, 32'h1);
    check("m0_irq_lat", {31'b0, irq}, 32'h0);
    cyc(1);
    check("m0_irq", {31'b0, irq}, 32'h1);
    wr(32'h0C, 32'h1);
    chk_reg("m0_w1c", 32'h0C, 32'h0);
    check("m0_irq_hold", {31'b0, irq}, 32'h1);
    cyc(1);
    check("m0_irq_drop", {31'b0, irq}, 32'h0);

    // Overflow; untouched all-ones compares also match on the way to 0xFFFFFFFF
    wr(32'h08, 32'h0);
    wr(32'h00, 32'hFFFF_FFFE);
    wr(32'h04, 32'h0);
    wr(32'h0C, 32'h8000_00FF);
    wr(32'h08, 32'h8000_0001);
    cyc(2);
    chk_reg("ovf_count", 32'h00, 32'h0);
    chk_reg("ovf_status", 32'h0C, 32'h8000_000E);
    cyc(1);
    check("ovf_irq", {31'b0, irq}, 32'h1);

    // W1C in the same cycle as a match set
    wr(32'h08, 32'h0);
    wr(32'h00, 32'h0);
    wr(32'h28, 32'd5);
    wr(32'h0C, 32'h8000_00FF);
    wr(32'h08, 32'h1);
    cyc(4);
    wr(32'h0C, 32'h2);
    chk_masked("w1c_race", 32'h0C, 32'h2, 32'h2);
    wr(32'h0C, 32'h2);
    chk_masked("w1c_after", 32'h0C, 32'h2, 32'h0);

    // COUNT write during a tick
    wr(32'h00, 32'h100);
    chk_reg("cnt_wr_tick", 32'h00, 32'h100);
    cyc(1);
    chk_reg("cnt_wr_next", 32'h00, 32'h101);

    // Channel 2 periodic / one-shot
    wr(32'h08, 32'h0);
    wr(32'h04, 32'h0);
    wr(32'h00, 32'h0);
    wr(32'h30, 32'd10);
    wr(32'h34, 32'd10);
    wr(32'h0C, 32'h8000_00FF);
    wr(32'h08, 32'h1);
    cyc(10);
    chk_masked("ch2_m10", 32'h0C, 32'h4, 32'h4);
    wr(32'h0C, 32'h4);
    cyc(8);
    chk_masked("ch2_t19", 32'h0C, 32'h4, 32'h0);
    cyc(1);
`ifdef SYSTEM_TIMER_AUTORELOAD_EN
    chk_masked("ch2_m20", 32'h0C, 32'h4, 32'h4);
`else
    chk_masked("ch2_m20", 32'h0C, 32'h4, 32'h0);
`endif
    wr(32'h0C, 32'h4);
    cyc(8);
    chk_masked("ch2_t29", 32'h0C, 32'h4, 32'h0);
    cyc(1);
    chk_reg("ch2_count30", 32'h00, 32'd30);
`ifdef SYSTEM_TIMER_AUTORELOAD_EN
    chk_masked("ch2_m30", 32'h0C, 32'h4, 32'h4);
    chk_reg("ch2_cmp", 32'h30, 32'd40);
    chk_reg("ch2_reload", 32'h34, 32'd10);
`else
    chk_masked("ch2_m30", 32'h0C, 32'h4, 32'h0);
    chk_reg("ch2_cmp", 32'h30, 32'd10);
    chk_reg("ch2_reload", 32'h34, 32'h0);
`endif

    // Asynchronous reset mid-operation
    reset = 1'b1;
    #1;
    chk_reg("arst_count", 32'h00, 32'h0);
    chk_reg("arst_status", 32'h0C, 32'h0);
    chk_reg("arst_cmp2", 32'h30, 32'hFFFF_FFFF);
    check("arst_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    wr(32'h08, 32'h1);
    cyc(1);
    chk_reg("arst_first_tick", 32'h00, 32'd1);

    // Randomized runs against the arithmetic model
    for (int it = 0; it < 25; it++) begin
      d = $urandom_range(0, 3);
      k = $urandom_range(1, 40);
      if ($urandom_range(0, 1) == 1) start = 32'hFFFF_FFFF - 32'($urandom_range(0, 12));
      else start = $urandom;
      m  = CH'($urandom);
      oe = 1'($urandom);
      for (int n = 0; n < CH; n++) off[n] = $urandom_range(1, 30);
      ctrl = 32'h1 | (32'(m) << 8) | (32'(oe) << 31);

      wr(32'h08, 32'h0);
      wr(32'h04, 32'(d));
      wr(32'h00, start);
      for (int n = 0; n < CH; n++) wr(32'h20 + 32'(8 * n), start + 32'(off[n]));
      wr(32'h0C, 32'h8000_00FF);
      wr(32'h08, ctrl);
      cyc(k);

      ticks   = longint'(k / (d + 1));
      tt      = longint'((k - 1) / (d + 1));
      need    = 64'h1_0000_0000 - longint'(start);
      st_exp  = (need <= ticks) ? 32'h8000_0000 : 32'h0;
      irq_exp = oe && (need <= tt);
      for (int n = 0; n < CH; n++) begin
        if (longint'(off[n]) <= ticks) st_exp[n] = 1'b1;
        if (m[n] && (longint'(off[n]) <= tt)) irq_exp = 1'b1;
      end
      chk_reg($sformatf("rnd%0d_count", it), 32'h00, start + 32'(ticks));
      chk_reg($sformatf("rnd%0d_status", it), 32'h0C, st_exp);
      check($sformatf("rnd%0d_irq", it), {31'b0, irq}, {31'b0, irq_exp});
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/system_timer_multi.md
# system_timer_multi

Parametrised multi-channel system timer: a free-running COUNT_WIDTH counter advanced by a programmable clock divider, with CHANNELS compare channels, sticky match/overflow status and a single level interrupt. It sits on the SoC peripheral bus (write/read/writeData/readData/address strobes) beside the CPU and provides time-base and scheduling interrupts. All state is in one clock domain with no ripple prescaler.

## Interface
- CHANNELS, 4: number of compare channels, 1..8.
- COUNT_WIDTH, 32: main counter and compare width, 8..32.
- DIV_WIDTH, 21: divider period width, 1..32.
- ADDR_WIDTH, 7: byte address width; must cover 0x20+8*(CHANNELS-1)+4.
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- write  input  1  register write strobe, one cycle per access.
- read  input  1  register read strobe.
- writeData  input  32  write data.
- readData  output  32  combinational read data; 0 when read is low or address is unmapped.
- address  input  ADDR_WIDTH  byte address, word aligned.
- irq  output  1  level interrupt, registered; reset 0.

## Operation
- Register map, with unused bits reading 0:
  - 0x00 COUNT, rw, COUNT_WIDTH bits; reset 0.
  - 0x04 DIVIDER, rw, DIV_WIDTH bits; reset 0.
  - 0x08 CTRL, rw; reset 0.
    - bit0 ENABLE.
    - bits[8+n] match IRQ enable for channel n.
    - bit31 overflow IRQ enable.
  - 0x0C STATUS: bits[n] match n, bit31 overflow.
    - Write-1-to-clear; writing 0 has no effect; reset 0.
  - 0x20+8n COMPAREn, rw; reset all-ones.
  - 0x24+8n RELOADn, rw; reset 0. Only present when the feature macro is defined.
- Divider:
  - divCount, internal, DIV_WIDTH bits; reset 0.
  - When ENABLE=1 and divCount==DIVIDER, a tick is generated and divCount returns to 0. Otherwise divCount increments.
  - Tick period is DIVIDER+1 clocks; DIVIDER=0 gives a tick every clock.
  - When ENABLE=0, divCount holds and no ticks occur.
- Counter:
  - On each tick, COUNT <= COUNT+1, wrapping modulo 2^COUNT_WIDTH.
  - A tick taking COUNT from all-ones to 0 sets STATUS[31].
- Match:
  - On a tick where COUNT+1 == COMPAREn, STATUS[n] is set on the same edge COUNT takes that value.
  - Software writes to COUNT or COMPAREn never generate a match.
- irq is registered: irq <= |(STATUS & enable mask), covering bits [CHANNELS-1:0] and bit31.

## Timing
- Read: combinational, same cycle as read.
- Write: takes effect on the clock edge at which write is sampled.
- A match or overflow reaches irq one clock after the STATUS bit sets.
- Simultaneous events:
  - COUNT write in a tick cycle: the written value wins and no match or overflow is evaluated. divCount still resets to 0.
  - DIVIDER write: divCount is forced to 0 on the same edge.
  - STATUS W1C in the same cycle as a set of the same bit: the set wins.
  - COMPAREn write in a tick cycle: the match is evaluated against the old COMPAREn.
- Writes to read-only or unmapped addresses are ignored.
- Reset mid-operation clears all registers, divCount, STATUS and irq asynchronously. The first tick after release occurs DIVIDER+1 clocks after ENABLE is set.

## Configuration
- SYSTEM_TIMER_AUTORELOAD_EN defined:
  - RELOADn registers exist.
  - On a match with RELOADn != 0, COMPAREn <= COMPAREn + RELOADn (modulo 2^COUNT_WIDTH) on the same edge, giving periodic interrupts.
  - With RELOADn == 0, the channel is one-shot.
- Not defined:
  - RELOADn addresses are unmapped: they read 0 and writes are ignored.
  - All channels are one-shot.
  - No reload storage or adders are synthesised.

## Test plan
- Reset, then read all registers:
  - COUNT=0, DIVIDER=0, CTRL=0, STATUS=0, COMPAREn=0xFFFFFFFF, irq=0.
  - readData=0 while read is low.
- DIVIDER=4, ENABLE=1 -> COUNT increments exactly every 5 clocks; after 50 clocks COUNT=10.
- DIVIDER=0, COMPARE0=3, CTRL=0x101 -> STATUS[0] sets on the edge COUNT becomes 3 and irq rises one clock later. W1C 0x1 clears STATUS[0], and irq drops the following clock.
- COUNT=0xFFFFFFFE, DIVIDER=0, CTRL=0x80000001 -> after 2 ticks COUNT=0, STATUS[31]=1, irq=1.
- Same-cycle events:
  - W1C of STATUS[1] in the match tick for channel 1 -> STATUS[1] remains 1.
  - COUNT write of 0x100 in a tick cycle -> COUNT=0x100.
- With SYSTEM_TIMER_AUTORELOAD_EN, COMPARE2=10, RELOAD2=10, DIVIDER=0 -> matches at COUNT 10, 20 and 30, and COMPARE2 reads 40 after the third match. Without the macro, only the match at 10 occurs and reading 0x34 returns 0.
